// File: rtl/vacc_dbuf_mc_pkg.sv
// Shared helpers for the X-engine accumulator blocks: log2 and accumulator width formula.
// Pure constants; no logic, latency or backpressure of its own.
package vacc_dbuf_mc_pkg;

  function automatic int log2_func(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width_f(input int input_width, input int acc_len_bits);
    return input_width + acc_len_bits;
  endfunction

endpackage

// File: rtl/vacc_dbuf_mc_if.sv
// Sample stream in, buffer readout and completion status out of the vector accumulator.
// No handshake: din_valid qualifies samples, the reader follows buf_done/buf_done_id.
interface vacc_dbuf_mc_if #(
  parameter int N_LANES     = 2,
  parameter int INPUT_WIDTH = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int VLB         = 3,
  parameter int SEL_W       = 4
);
  logic                           sync;
  logic [SEL_W-1:0]               acc_len_sel;
  logic                           din_valid;
  logic [N_LANES*INPUT_WIDTH-1:0] din;
  logic                           buf_sel;
  logic [VLB-1:0]                 ant_sel_a;
  logic [VLB-1:0]                 ant_sel_b;
  logic [N_LANES*ACC_WIDTH-1:0]   dout_a;
  logic [N_LANES*ACC_WIDTH-1:0]   dout_b;
  logic                           buf_done;
  logic                           buf_done_id;
  logic [N_LANES-1:0]             ovf;

  modport master (
    output sync, acc_len_sel, din_valid, din, buf_sel, ant_sel_a, ant_sel_b,
    input  dout_a, dout_b, buf_done, buf_done_id, ovf
  );

  modport slave (
    input  sync, acc_len_sel, din_valid, din, buf_sel, ant_sel_a, ant_sel_b,
    output dout_a, dout_b, buf_done, buf_done_id, ovf
  );
endinterface

// File: rtl/bram_tdp.sv
// Simple dual-port RAM: port A writes, port B reads with one registered cycle of latency.
// No backpressure; contents are not reset.
module bram_tdp #(
  parameter int DW = 12,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
    b_dout <= mem[b_addr];
  end
endmodule

// File: rtl/vacc_dbuf_mc_lane.sv
// One accumulator lane: sign-extend, guard-bit add, clamp or wrap, sticky overflow; sum is combinational.
// Advances only when en is high; clr restarts the lane and drops its sticky bit.
module vacc_lane #(
  parameter int INPUT_WIDTH = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   first,
  input  logic                   vec_end,
  input  logic [INPUT_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic                   ovf_snap
);
  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic [ACC_WIDTH:0]   ext_din;
  logic [ACC_WIDTH:0]   raw;
  logic                 ovf_now;

  assign ext_din  = {{(ACC_WIDTH+1-INPUT_WIDTH){din[INPUT_WIDTH-1]}}, din};
  assign raw      = first ? ext_din : ({acc[ACC_WIDTH-1], acc} + ext_din);
  assign ovf_now  = raw[ACC_WIDTH] ^ raw[ACC_WIDTH-1];
  // Includes the current sample so the last write of a vector is reported with it.
  assign ovf_snap = sticky | ovf_now;

  always_comb begin
    sum = raw[ACC_WIDTH-1:0];
    if (ovf_now && SATURATE != 0) sum = {raw[ACC_WIDTH], {(ACC_WIDTH-1){~raw[ACC_WIDTH]}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (en) begin
      acc    <= sum;
      sticky <= vec_end ? 1'b0 : ovf_snap;
    end
  end
endmodule

// File: rtl/vacc_dbuf_mc.sv
// Multi-lane vector accumulator into a double-buffered RAM; readout address to dout takes 2 cycles.
// No backpressure: din_valid gates progress, the reader reads only the half named by buf_done_id.
module vacc_dbuf_mc
  import vacc_dbuf_mc_pkg::*;
#(
  parameter int INPUT_WIDTH   = 4,
  parameter int ACC_LEN_BITS  = 8,
  parameter int VECTOR_LENGTH = 8,
  parameter int N_LANES       = 2,
  parameter int SATURATE      = 1,
  parameter int ACC_WIDTH     = acc_width_f(INPUT_WIDTH, ACC_LEN_BITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  vacc_dbuf_mc_if.slave bus
);
  localparam int VLB   = log2_func(VECTOR_LENGTH);
  localparam int SEL_W = log2_func(ACC_LEN_BITS + 1);

  logic [ACC_LEN_BITS-1:0]      smp_cnt;
  logic [ACC_LEN_BITS-1:0]      smp_max;
  logic [VLB-1:0]               elem_cnt;
  logic [SEL_W-1:0]             len_l;
  logic                         wr_half;
  logic                         done_pend;
  logic [N_LANES-1:0]           ovf_pend;
  logic [N_LANES-1:0]           ovf_snap;
  logic                         adv, first, smp_last, elem_last, wr_en, vec_end;
  logic [N_LANES*ACC_WIDTH-1:0] rd_a, rd_b;

  assign smp_max   = ~({ACC_LEN_BITS{1'b1}} << len_l);
  assign adv       = bus.din_valid & ~bus.sync;
  assign first     = (smp_cnt == '0);
  assign smp_last  = (smp_cnt == smp_max);
  assign elem_last = (elem_cnt == VLB'(VECTOR_LENGTH - 1));
  assign wr_en     = adv & smp_last;
  assign vec_end   = wr_en & elem_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt         <= '0;
      elem_cnt        <= '0;
      wr_half         <= 1'b0;
      len_l           <= SEL_W'(ACC_LEN_BITS);
      done_pend       <= 1'b0;
      ovf_pend        <= '0;
      bus.buf_done    <= 1'b0;
      bus.buf_done_id <= 1'b0;
      bus.ovf         <= '0;
    end else begin
      done_pend    <= 1'b0;
      bus.buf_done <= done_pend;
      // wr_half has already flipped, so the finished half is its complement.
      if (done_pend) begin
        bus.buf_done_id <= ~wr_half;
        bus.ovf         <= ovf_pend;
      end
      if (bus.sync) begin
        smp_cnt  <= '0;
        elem_cnt <= '0;
        wr_half  <= 1'b0;
        len_l    <= (bus.acc_len_sel > SEL_W'(ACC_LEN_BITS)) ? SEL_W'(ACC_LEN_BITS) : bus.acc_len_sel;
      end else if (bus.din_valid) begin
        if (smp_last) begin
          smp_cnt  <= '0;
          elem_cnt <= elem_cnt + 1'b1;
        end else begin
          smp_cnt  <= smp_cnt + 1'b1;
        end
        if (vec_end) begin
          wr_half   <= ~wr_half;
          done_pend <= 1'b1;
          ovf_pend  <= ovf_snap;
        end
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic [ACC_WIDTH-1:0] sum;

    vacc_lane #(
      .INPUT_WIDTH(INPUT_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SATURATE   (SATURATE)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .clr     (bus.sync),
      .first   (first),
      .vec_end (vec_end),
      .din     (bus.din[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .sum     (sum),
      .ovf_snap(ovf_snap[g])
    );

    // Two copies written identically so both readout ports get a private read port.
    bram_tdp #(.DW(ACC_WIDTH), .AW(VLB + 1)) u_mem_a (
      .clk   (clk),
      .a_we  (wr_en),
      .a_addr({wr_half, elem_cnt}),
      .a_din (sum),
      .b_addr({bus.buf_sel, bus.ant_sel_a}),
      .b_dout(rd_a[g*ACC_WIDTH +: ACC_WIDTH])
    );

    bram_tdp #(.DW(ACC_WIDTH), .AW(VLB + 1)) u_mem_b (
      .clk   (clk),
      .a_we  (wr_en),
      .a_addr({wr_half, elem_cnt}),
      .a_din (sum),
      .b_addr({bus.buf_sel, bus.ant_sel_b}),
      .b_dout(rd_b[g*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout_a <= '0;
      bus.dout_b <= '0;
    end else begin
      bus.dout_a <= rd_a;
      bus.dout_b <= rd_b;
    end
  end
endmodule

// File: tb/tb_vacc_dbuf_mc.sv
// Bench for vacc_dbuf_mc: default build plus a 6-bit accumulator build that can saturate.
// Both builds share stimulus; use2 selects which one is observed.
module tb_vacc_dbuf_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vacc_dbuf_mc_if #(.N_LANES(2), .INPUT_WIDTH(4), .ACC_WIDTH(12), .VLB(3), .SEL_W(4)) bus ();
  vacc_dbuf_mc_if #(.N_LANES(2), .INPUT_WIDTH(4), .ACC_WIDTH(6),  .VLB(3), .SEL_W(4)) bus2 ();

  vacc_dbuf_mc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  vacc_dbuf_mc #(.ACC_WIDTH(6), .SATURATE(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic       sync_s = 1'b0, valid_s = 1'b0, buf_sel_s = 1'b0;
  logic [3:0] sel_s = 4'd0;
  logic [7:0] din_s = 8'd0;
  logic [2:0] ant_a_s = 3'd0, ant_b_s = 3'd0;

  assign bus.sync = sync_s;    assign bus2.sync = sync_s;
  assign bus.acc_len_sel = sel_s;  assign bus2.acc_len_sel = sel_s;
  assign bus.din_valid = valid_s;  assign bus2.din_valid = valid_s;
  assign bus.din = din_s;      assign bus2.din = din_s;
  assign bus.buf_sel = buf_sel_s;  assign bus2.buf_sel = buf_sel_s;
  assign bus.ant_sel_a = ant_a_s;  assign bus2.ant_sel_a = ant_a_s;
  assign bus.ant_sel_b = ant_b_s;  assign bus2.ant_sel_b = ant_b_s;

  logic use2 = 1'b0;
  logic signed [11:0] a0, a1, b0, b1;
  logic m_done, m_id;
  logic [1:0] m_ovf;

  always_comb begin
    if (use2) begin
      a0 = {{6{bus2.dout_a[5]}},  bus2.dout_a[5:0]};
      a1 = {{6{bus2.dout_a[11]}}, bus2.dout_a[11:6]};
      b0 = {{6{bus2.dout_b[5]}},  bus2.dout_b[5:0]};
      b1 = {{6{bus2.dout_b[11]}}, bus2.dout_b[11:6]};
      m_done = bus2.buf_done; m_id = bus2.buf_done_id; m_ovf = bus2.ovf;
    end else begin
      a0 = bus.dout_a[11:0]; a1 = bus.dout_a[23:12];
      b0 = bus.dout_b[11:0]; b1 = bus.dout_b[23:12];
      m_done = bus.buf_done; m_id = bus.buf_done_id; m_ovf = bus.ovf;
    end
  end

  typedef struct packed {
    bit do_sync; logic [3:0] sel; int d0; int d1; bit gap;
    int exp0; int exp1; logic [1:0] exp_ovf; bit use2;
  } vec_t;

  typedef struct packed {
    logic id; logic [1:0] ovf; logic [7:0][11:0] e0; logic [7:0][11:0] e1;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[10];
  int   n_cmp = 0, n_bad = 0, stray = 0, cur_l = 8;
  logic half_m = 1'b0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sync with din_valid high and junk data: sync must win.
  task automatic do_sync(input logic [3:0] sel);
    sync_s = 1'b1; sel_s = sel; valid_s = 1'b1; din_s = 8'h77;
    tick();
    sync_s = 1'b0; valid_s = 1'b0;
    if (m_done) stray++;
    cur_l = (sel > 4'd8) ? 8 : int'(sel);
    half_m = 1'b0;
  endtask

  task automatic drive(input int d0, input int d1, input bit gap, input bit last);
    valid_s = 1'b1; din_s = {4'(d1), 4'(d0)};
    tick();
    if (m_done) stray++;
    if (gap && !last) begin
      valid_s = 1'b0; din_s = 8'h77;
      tick();
      if (m_done) stray++;
    end
    valid_s = 1'b0;
  endtask

  task automatic check_done(input string nm);
    bit  found;
    int  lat;
    sb_t r;
    found = 1'b0; lat = 0; valid_s = 1'b0;
    while (!found && lat < 16) begin
      tick();
      lat++;
      found = m_done;
    end
    chk({nm, "_done_lat"}, lat, 1);
    chk({nm, "_stray_done"}, stray, 0);
    stray = 0;
    r = sb.pop_front();
    chk({nm, "_id"}, m_id, r.id);
    chk({nm, "_ovf"}, m_ovf, r.ovf);
    tick();
    chk({nm, "_pulse"}, m_done, 0);
    for (int e = 0; e < 8; e++) begin
      buf_sel_s = r.id; ant_a_s = 3'(e); ant_b_s = 3'(7 - e);
      tick();
      tick();
      chk($sformatf("%s_a0_e%0d", nm, e), a0, $signed(r.e0[e]));
      chk($sformatf("%s_a1_e%0d", nm, e), a1, $signed(r.e1[e]));
      chk($sformatf("%s_b0_e%0d", nm, 7 - e), b0, $signed(r.e0[7 - e]));
      chk($sformatf("%s_b1_e%0d", nm, 7 - e), b1, $signed(r.e1[7 - e]));
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    sb_t r;
    int  n;
    use2 = v.use2;
    if (v.do_sync) do_sync(v.sel);
    r.id = half_m; r.ovf = v.exp_ovf;
    for (int e = 0; e < 8; e++) begin
      r.e0[e] = 12'(v.exp0);
      r.e1[e] = 12'(v.exp1);
    end
    sb.push_back(r);
    half_m = ~half_m;
    n = 1 << cur_l;
    for (int e = 0; e < 8; e++)
      for (int s = 0; s < n; s++)
        drive(v.d0, v.d1, v.gap, (e == 7) && (s == n - 1));
    check_done(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t r;
    //               sync sel    d0  d1 gap  exp0   exp1  ovf    use2
    tbl[0] = '{1'b1, 4'd2,   1,  1, 1'b0,    4,     4, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 4'd2,   1,  1, 1'b0,    4,     4, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 4'd2,   1,  1, 1'b1,    4,     4, 2'b00, 1'b0};
    tbl[3] = '{1'b1, 4'd8,   7, -8, 1'b0, 1792, -2048, 2'b00, 1'b0};
    tbl[4] = '{1'b1, 4'd15, -1,  3, 1'b0, -256,   768, 2'b00, 1'b0};
    tbl[5] = '{1'b1, 4'd0,  -3,  5, 1'b0,   -3,     5, 2'b00, 1'b0};
    tbl[6] = '{1'b0, 4'd0,   6, -7, 1'b1,    6,    -7, 2'b00, 1'b0};
    tbl[7] = '{1'b1, 4'd3,   7, -1, 1'b0,   31,    -8, 2'b01, 1'b1};
    tbl[8] = '{1'b0, 4'd3,   1,  1, 1'b0,    8,     8, 2'b00, 1'b1};
    tbl[9] = '{1'b0, 4'd3,   0, -8, 1'b1,    0,   -32, 2'b10, 1'b1};

    tick();
    tick();
    chk("rst_dout_a", {8'd0, bus.dout_a}, 0);
    chk("rst_dout_b", {8'd0, bus.dout_b}, 0);
    chk("rst_buf_done", bus.buf_done, 0);
    chk("rst_buf_done_id", bus.buf_done_id, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Sync mid-element 3 discards the partial vector.
    use2 = 1'b0;
    do_sync(4'd1);
    for (int s = 0; s < 7; s++) drive(5, 5, 1'b0, 1'b0);
    run_vec('{1'b1, 4'd1, 2, -2, 1'b0, 4, -4, 2'b00, 1'b0}, "midsync");

    // Distinct per-element values, then exact 2-cycle read latency.
    do_sync(4'd0);
    r.id = 1'b0; r.ovf = 2'b00;
    for (int e = 0; e < 8; e++) begin
      r.e0[e] = 12'(e);
      r.e1[e] = 12'(-e);
    end
    sb.push_back(r);
    half_m = 1'b1;
    for (int e = 0; e < 8; e++) drive(e, -e, 1'b0, e == 7);
    check_done("elemidx");
    buf_sel_s = 1'b0; ant_a_s = 3'd1; ant_b_s = 3'd1;
    tick(); tick(); tick();
    ant_a_s = 3'd5; ant_b_s = 3'd2;
    tick();
    chk("rd_t1_a0", a0, 1);
    chk("rd_t1_b1", b1, -1);
    tick();
    chk("rd_t2_a0", a0, 5);
    chk("rd_t2_a1", a1, -5);
    chk("rd_t2_b0", b0, 2);
    chk("rd_t2_b1", b1, -2);

    run_vec('{1'b0, 4'd0, 3, -4, 1'b0, 3, -4, 2'b00, 1'b0}, "half1");

    // Asynchronous reset in the middle of a vector.
    buf_sel_s = 1'b1; ant_a_s = 3'd5; ant_b_s = 3'd4;
    tick(); tick();
    chk("pre_rst_a0", a0, 3);
    for (int s = 0; s < 5; s++) drive(2, 2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout_a", {8'd0, bus.dout_a}, 0);
    chk("midrst_dout_b", {8'd0, bus.dout_b}, 0);
    chk("midrst_buf_done_id", bus.buf_done_id, 0);
    chk("midrst_buf_done", bus.buf_done, 0);
    chk("midrst_ovf", bus.ovf, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    half_m = 1'b0; cur_l = 8; stray = 0;
    run_vec('{1'b0, 4'd8, 1, -1, 1'b0, 256, -256, 2'b00, 1'b0}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
